// File: rtl/ledwalker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ledwalker_pkg
// Description : Shared state encoding and counter-width helper for the LED
//               walker sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ledwalker_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_DOWN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_UP   = ST_UP,
    S_DOWN = ST_DOWN
  } state_t;

  // Width of a down-counter that must hold STEP_CYCLES-1 without overflow
  function automatic int cnt_width(input int step_cycles);
    return $clog2(step_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ledwalker_tick.sv
`default_nettype none
// ============================================================================
// Module      : ledwalker_tick
// Description : Step-rate down-counter. Loadable to STEP_CYCLES-1; o_tick is
//               high for one cycle whenever the count reaches zero, after
//               which the counter reloads itself.
// Revision    : 1.0 - initial release
// ============================================================================
module ledwalker_tick
  import ledwalker_pkg::*;
#(
  parameter int STEP_CYCLES = 10000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_load,
  output logic o_tick
);

  localparam int                 c_cnt_w  = cnt_width(STEP_CYCLES);
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(STEP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  // Reload on an explicit load or on each tick, otherwise count down
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= c_reload;
    end else begin
      r_cnt <= r_cnt - c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ledwalker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ledwalker_ctrl
// Description : Switch-to-LED sequencer. While idle, i_sw is registered onto
//               o_led[0]. A start strobe walks one lit LED from bit 0 to the
//               top bit and back, holding each position STEP_CYCLES cycles,
//               then hands the LEDs back to the switch.
//               Build option LEDWALKER_SYNC_EN: two-flop synchronizers on
//               i_sw/i_stb plus rising-edge detection on the strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ledwalker_ctrl
  import ledwalker_pkg::*;
#(
  parameter int NLEDS       = 8,
  parameter int STEP_CYCLES = 10000000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_sw,
  input  logic             i_stb,
  output logic             o_busy,
  output logic [NLEDS-1:0] o_led
);

  logic w_sw;
  logic w_stb;

`ifdef LEDWALKER_SYNC_EN
  logic r_sw_meta;
  logic r_sw_sync;
  logic r_stb_meta;
  logic r_stb_sync;
  logic r_stb_prev;

  // Two-flop synchronizers plus a delayed copy of the strobe for edge detect
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sw_meta  <= 1'b0;
      r_sw_sync  <= 1'b0;
      r_stb_meta <= 1'b0;
      r_stb_sync <= 1'b0;
      r_stb_prev <= 1'b0;
    end else begin
      r_sw_meta  <= i_sw;
      r_sw_sync  <= r_sw_meta;
      r_stb_meta <= i_stb;
      r_stb_sync <= r_stb_meta;
      r_stb_prev <= r_stb_sync;
    end
  end

  assign w_sw  = r_sw_sync;
  // A held button yields a single start request
  assign w_stb = r_stb_sync & ~r_stb_prev;
`else
  assign w_sw  = i_sw;
  assign w_stb = i_stb;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NLEDS-1:0] r_led;
  logic [NLEDS-1:0] w_led_nxt;
  logic [NLEDS-1:0] w_idle_led;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_load;
  logic             w_tick;

  assign w_idle_led = {{(NLEDS-1){1'b0}}, w_sw};

  ledwalker_tick #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_tick (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_load),
    .o_tick    (w_tick)
  );

  // Next-state, next-LED and counter-load decode
  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_busy_nxt  = r_busy;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_led_nxt  = w_idle_led;
        w_busy_nxt = 1'b0;
        if (w_stb) begin
          // Start edge owns the LEDs immediately; i_sw is not sampled here
          w_state_nxt = S_UP;
          w_led_nxt   = {{(NLEDS-1){1'b0}}, 1'b1};
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      S_UP: begin
        if (w_tick) begin
          if (r_led[NLEDS-1]) begin
            w_state_nxt = S_DOWN;
            w_led_nxt   = r_led >> 1;
          end else begin
            w_led_nxt   = r_led << 1;
          end
        end
      end
      S_DOWN: begin
        if (w_tick) begin
          if (r_led[0]) begin
            w_state_nxt = S_IDLE;
            w_led_nxt   = w_idle_led;
            w_busy_nxt  = 1'b0;
          end else begin
            w_led_nxt   = r_led >> 1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_led_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any walk in progress
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_led   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_led  = r_led;
  assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ledwalker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ledwalker_ctrl
// Description : Directed bench for ledwalker_ctrl. One instance with NLEDS=8,
//               STEP_CYCLES=4 and one with NLEDS=2, STEP_CYCLES=1. Expected
//               {busy, led} values are queued as stimulus is driven and
//               compared one per clock after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ledwalker_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sw, stb;
  logic       sw2, stb2;
  logic       busy, busy2;
  logic [7:0] led;
  logic [1:0] led2;

  always #5 clk = ~clk;

  ledwalker_ctrl #(
    .NLEDS       (8),
    .STEP_CYCLES (4)
  ) u_dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_sw      (sw),
    .i_stb     (stb),
    .o_busy    (busy),
    .o_led     (led)
  );

  ledwalker_ctrl #(
    .NLEDS       (2),
    .STEP_CYCLES (1)
  ) u_dut2 (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_sw      (sw2),
    .i_stb     (stb2),
    .o_busy    (busy2),
    .o_led     (led2)
  );

  logic [8:0] q[$];
  int         checks = 0;
  int         errors = 0;
  string      tag = "";
  bit         sel2 = 1'b0;

  // Lit LED at walk cycle k for NLEDS=8, STEP_CYCLES=4
  function automatic logic [7:0] walk_led(input int k);
    int p;
    int idx;
    p   = k / 4;
    idx = (p < 8) ? p : (14 - p);
    return 8'(1 << idx);
  endfunction

  task automatic push(input logic [7:0] l, input logic b);
    q.push_back({b, l});
  endtask

  task automatic push_walk(input int from, input int to);
    for (int k = from; k < to; k++) push(walk_led(k), 1'b1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      logic [8:0] e;
      logic [8:0] o;
      @(posedge clk);
      #1;
      o = sel2 ? {busy2, 6'b0, led2} : {busy, led};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty, observed busy=%b led=%h", tag, o[8], o[7:0]);
      end else begin
        e = q.pop_front();
        assert (o === e) else begin
          errors++;
          $error("FAIL %s: observed busy=%b led=%h expected busy=%b led=%h",
                 tag, o[8], o[7:0], e[8], e[7:0]);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; sw = 1'b1; stb = 1'b0; sw2 = 1'b0; stb2 = 1'b0;

    tag = "reset";
    repeat (3) push(8'h00, 1'b0);
    run(3);

    reset_n = 1'b1;
    tag = "idle_sw1";  push(8'h01, 1'b0); run(1);
    sw = 1'b0;
    tag = "idle_sw0";  push(8'h00, 1'b0); run(1);
    sw = 1'b1;
    tag = "idle_sw1b"; push(8'h01, 1'b0); run(1);

    // Single-pulse walk; switch activity during the walk is ignored
    stb = 1'b1; sw = 1'b0;
    tag = "walk_start"; push_walk(0, 1); run(1);
    stb = 1'b0; sw = 1'b1;
    tag = "walk";       push_walk(1, 59); run(58);
    sw = 1'b0;
    tag = "walk_last";  push_walk(59, 60); run(1);
    tag = "walk_end";   push(8'h00, 1'b0); run(1);
    sw = 1'b1;
    tag = "walk_ret";   push(8'h01, 1'b0); run(1);

    // Strobes mid-walk are neither acted on nor queued
    stb = 1'b1;
    tag = "ign_start"; push_walk(0, 1); run(1);
    tag = "ign_walk";
    for (int k = 1; k < 60; k++) begin
      stb = (k == 5 || k == 30);
      push_walk(k, k + 1);
      run(1);
    end
    stb = 1'b0;
    tag = "ign_end"; push(8'h01, 1'b0); push(8'h01, 1'b0); run(2);

    // Reset mid-walk aborts and idle passthrough resumes
    stb = 1'b1;
    tag = "rst_start"; push_walk(0, 1); run(1);
    stb = 1'b0;
    tag = "rst_walk";  push_walk(1, 20); run(19);
    reset_n = 1'b0;
    tag = "mid_reset"; push(8'h00, 1'b0); run(1);
    reset_n = 1'b1;
    tag = "post_rst";  push(8'h01, 1'b0); push(8'h01, 1'b0); run(2);

    // NLEDS=2, STEP_CYCLES=1 with the strobe held: 01,02,01 then one idle cycle
    sel2 = 1'b1;
    tag = "n2_idle"; push(8'h00, 1'b0); run(1);
    stb2 = 1'b1;
    tag = "n2_held";
    repeat (3) begin
      push(8'h01, 1'b1); push(8'h02, 1'b1); push(8'h01, 1'b1); push(8'h00, 1'b0);
    end
    run(12);
    stb2 = 1'b0;
    tag = "n2_stop"; push(8'h00, 1'b0); run(1);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
